// File: rtl/btn_conditioner_if.sv
// Button-path bundle between the board/tick sources and the conditioner.
// The master drives the raw buttons and the game tick; the slave returns the conditioned outputs.
interface btn_conditioner_if;
    logic [2:0] btn_in;
    logic       sim_clk;
    logic [2:0] btn_level;
    logic [2:0] btn_press;

    modport master (
        output btn_in,
        output sim_clk,
        input  btn_level,
        input  btn_press
    );

    modport slave (
        input  btn_in,
        input  sim_clk,
        output btn_level,
        output btn_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises and debounces three buttons, and turns each accepted press into an event
// that is held for exactly one sim_clk period.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic              clk,
    input logic              reset,
    btn_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        Idle,
        PressWait,
        Held,
        ReleaseWait
    } btnState_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [2:0] syncFirst;
    logic [2:0] syncS;
    logic       tickT1;
    logic       tickT2;
    logic       tick;
    logic [2:0] riseStrobe;
    logic [2:0] level;
    logic [2:0] pendingQ;
    logic [2:0] pressQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncFirst <= '0;
            syncS     <= '0;
            tickT1    <= 1'b0;
            tickT2    <= 1'b0;
        end else begin
            syncFirst <= bus.btn_in;
            syncS     <= syncFirst;
            tickT1    <= bus.sim_clk;
            tickT2    <= tickT1;
        end
    end

    // sim_clk is data here; a tick marks the first clk cycle after its rising edge.
    assign tick = tickT1 & ~tickT2;

    for (genvar i = 0; i < 3; i++) begin : gBtn
        btnState_t        stateQ;
        btnState_t        stateD;
        logic [CNT_W-1:0] cntQ;
        logic [CNT_W-1:0] cntD;
        logic             rise;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stateQ <= Idle;
                cntQ   <= '0;
            end else begin
                stateQ <= stateD;
                cntQ   <= cntD;
            end
        end

        always_comb begin
            stateD = stateQ;
            cntD   = cntQ;
            rise   = 1'b0;
            case (stateQ)
                Idle: begin
                    if (syncS[i]) begin
                        stateD = PressWait;
                        cntD   = CntOne;
                    end else begin
                        cntD = '0;
                    end
                end
                PressWait: begin
                    if (!syncS[i]) begin
                        stateD = Idle;
                        cntD   = '0;
                    end else if (cntQ == CntLast) begin
                        stateD = Held;
                        cntD   = '0;
                        rise   = 1'b1;
                    end else begin
                        cntD = cntQ + CntOne;
                    end
                end
                Held: begin
                    if (!syncS[i]) begin
                        stateD = ReleaseWait;
                        cntD   = CntOne;
                    end
                end
                ReleaseWait: begin
                    if (syncS[i]) begin
                        stateD = Held;
                        cntD   = '0;
                    end else if (cntQ == CntLast) begin
                        stateD = Idle;
                        cntD   = '0;
                    end else begin
                        cntD = cntQ + CntOne;
                    end
                end
                default: begin
                    stateD = Idle;
                    cntD   = '0;
                end
            endcase
        end

        assign riseStrobe[i] = rise;
        assign level[i]      = (stateQ == Held) || (stateQ == ReleaseWait);
    end

    // A rise landing on the tick edge is kept pending and delivered on the following tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendingQ <= '0;
            pressQ   <= '0;
        end else if (tick) begin
            pressQ   <= pendingQ;
            pendingQ <= riseStrobe;
        end else begin
            pendingQ <= pendingQ | riseStrobe;
        end
    end

    assign bus.btn_level = level;
    assign bus.btn_press = pressQ;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button activity,
// compared every cycle against a run-length reference model of the debounce and tick rules.
module tb_btn_conditioner;

    localparam int unsigned Deb = 4;
    localparam int unsigned CntW = 3;

    logic clk;
    logic reset;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (CntW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCnt  = 0;
    int checkCnt = 0;
    int failCnt  = 0;

    // Reference model: button history, run length of samples disagreeing with the level.
    logic [2:0] sync1M, sM, levelM, pendingM, pressM;
    logic       t1M, t2M;
    int         runM[3];

    bit simAuto;
    int simPhase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        sync1M   = '0;
        sM       = '0;
        levelM   = '0;
        pendingM = '0;
        pressM   = '0;
        t1M      = 1'b0;
        t2M      = 1'b0;
        for (int i = 0; i < 3; i++) runM[i] = 0;
    endtask

    task automatic modelStep();
        logic       tickM;
        logic [2:0] riseM;
        tickM = t1M && !t2M;
        riseM = '0;
        for (int i = 0; i < 3; i++) begin
            if (sM[i] !== levelM[i]) runM[i]++;
            else runM[i] = 0;
            if (runM[i] == int'(Deb)) begin
                levelM[i] = ~levelM[i];
                runM[i]   = 0;
                if (levelM[i]) riseM[i] = 1'b1;
            end
        end
        if (tickM) begin
            pressM   = pendingM;
            pendingM = riseM;
        end else begin
            pendingM = pendingM | riseM;
        end
        sM     = sync1M;
        sync1M = bus.btn_in;
        t2M    = t1M;
        t1M    = bus.sim_clk;
    endtask

    // One clk cycle: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (reset) modelClear();
        else modelStep();
        @(negedge clk);
        chk("level", 32'(bus.btn_level), 32'(levelM));
        chk("press", 32'(bus.btn_press), 32'(pressM));
        if (simAuto) begin
            simPhase    = (simPhase + 1) % 20;
            bus.sim_clk = (simPhase >= 10);
        end
    endtask

    // Edges until the selected output bit reaches v; -1 if the bound expires.
    task automatic waitSig(input bit usePress, input int b, input logic v, output int n);
        n = 0;
        while (((usePress ? bus.btn_press[b] : bus.btn_level[b]) !== v) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) n = -1;
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        logic [5:0] bouncePat;

        reset       = 1'b1;
        bus.btn_in  = '0;
        bus.sim_clk = 1'b0;
        simAuto     = 1'b1;
        simPhase    = 0;
        modelClear();
        #1;
        chk("reset_level", 32'(bus.btn_level), 32'd0);
        chk("reset_press", 32'(bus.btn_press), 32'd0);
        repeat (3) cyc();
        reset = 1'b0;
        repeat (25) cyc();

        // Clean press on button 0.
        bus.btn_in[0] = 1'b1;
        waitSig(1'b0, 0, 1'b1, n);
        chk("clean_level_edges", 32'(n), 32'd6);
        waitSig(1'b1, 0, 1'b1, n);
        chk("clean_press_phase", 32'(simPhase), 32'd12);
        chk("clean_other_bits", 32'(bus.btn_press[2:1]), 32'd0);
        n = 0;
        while (bus.btn_press[0] === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        chk("clean_press_len", 32'(n), 32'd20);

        // Hold then release: no event on release.
        repeat (20) cyc();
        bus.btn_in[0] = 1'b0;
        waitSig(1'b0, 0, 1'b0, n);
        chk("release_edges", 32'(n), 32'd6);
        for (int i = 0; i < 45; i++) begin
            cyc();
            if (i % 15 == 0) chk("release_no_press", 32'(bus.btn_press[0]), 32'd0);
        end

        // Short low glitch while held.
        bus.btn_in[0] = 1'b1;
        waitSig(1'b0, 0, 1'b1, n);
        repeat (30) cyc();
        bus.btn_in[0] = 1'b0;
        repeat (2) cyc();
        bus.btn_in[0] = 1'b1;
        repeat (12) cyc();
        chk("glitch_level", 32'(bus.btn_level[0]), 32'd1);
        bus.btn_in[0] = 1'b0;
        repeat (40) cyc();

        // Bounce on button 1, then steady high.
        bouncePat = 6'b101101;
        for (int k = 0; k < 5; k++) begin
            bus.btn_in[1] = bouncePat[5-k];
            cyc();
        end
        bus.btn_in[1] = 1'b1;
        waitSig(1'b0, 1, 1'b1, n);
        chk("bounce_level_edges", 32'(n), 32'd6);
        rises = 0;
        prev  = bus.btn_press[1];
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (bus.btn_press[1] === 1'b1 && prev !== 1'b1) rises++;
            prev = bus.btn_press[1];
        end
        chk("bounce_one_event", 32'(rises), 32'd1);
        bus.btn_in[1] = 1'b0;
        repeat (40) cyc();

        // Rise strobe coincident with a tick: event slips to the next tick.
        simAuto     = 1'b0;
        bus.sim_clk = 1'b0;
        repeat (6) cyc();
        bus.btn_in[0] = 1'b1;
        repeat (4) cyc();
        bus.sim_clk = 1'b1;
        repeat (2) cyc();
        chk("coinc_level", 32'(bus.btn_level[0]), 32'd1);
        chk("coinc_press_held_off", 32'(bus.btn_press[0]), 32'd0);
        repeat (3) cyc();
        bus.sim_clk = 1'b0;
        repeat (3) cyc();
        bus.sim_clk = 1'b1;
        cyc();
        chk("coinc_press_latency", 32'(bus.btn_press[0]), 32'd0);
        cyc();
        chk("coinc_press_next", 32'(bus.btn_press[0]), 32'd1);
        bus.btn_in[0] = 1'b0;
        repeat (5) cyc();
        bus.sim_clk = 1'b0;
        simPhase    = 0;
        simAuto     = 1'b1;
        repeat (40) cyc();

        // All three at once land in one tick period.
        bus.btn_in = 3'b111;
        n = 0;
        while (bus.btn_press === 3'b000 && n < 100) begin
            cyc();
            n++;
        end
        chk("all_three_press", 32'(bus.btn_press), 32'd7);
        bus.btn_in = 3'b000;
        repeat (40) cyc();

        // Reset while btn_press[2] is high, button kept held.
        bus.btn_in[2] = 1'b1;
        waitSig(1'b1, 2, 1'b1, n);
        chk("rst_press_seen", 32'(bus.btn_press[2]), 32'd1);
        #2;
        reset = 1'b1;
        modelClear();
        #1;
        chk("rst_async_level", 32'(bus.btn_level), 32'd0);
        chk("rst_async_press", 32'(bus.btn_press), 32'd0);
        cyc();
        reset = 1'b0;
        waitSig(1'b0, 2, 1'b1, n);
        chk("rst_relevel_edges", 32'(n), 32'd6);
        waitSig(1'b1, 2, 1'b1, n);
        chk("rst_fresh_press", 32'(bus.btn_press[2]), 32'd1);
        bus.btn_in[2] = 1'b0;
        repeat (40) cyc();

        // Random activity, checked cycle by cycle against the model.
        for (int it = 0; it < 80; it++) begin
            bus.btn_in = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 14)) cyc();
        end
        bus.btn_in = '0;
        repeat (40) cyc();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
